calc_stack_engine: RTL and testbench

//  Multi-context, WIDTH-lane boolean stack evaluator; successor to the two-context ping-pong calculation stack.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_ctx_stack.sv | 75 +++++++
 rtl/calc_stack_engine.sv | 206 ++++++++++++++++++++
 tb/tb_calc_stack_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the multi-context boolean stack evaluator.
//   - opcode encodings carried on cmd_op
//   - bit positions of acc_op (cmd_lut[1:0]) for the ACC opcode
//   - width helpers for context ids and depth counters
package calc_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_LUT  = 3'd3;
  localparam logic [2:0] OP_ACC  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd6;

  // acc_op[ACC_INV_TOP] inverts s0, acc_op[ACC_INV_VAL] inverts cmd_val
  localparam int unsigned ACC_INV_TOP = 0;
  localparam int unsigned ACC_INV_VAL = 1;

  // Index width for n items; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold 0..n inclusive
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/calc_ctx_stack.sv
// One context's stack: DEPTH words of WIDTH bits plus a depth counter.
// Ports:
//   clk, reset   clock, synchronous active-low reset (clears depth only)
//   push         write wr_data above the current top, depth+1
//   pop          depth-1
//   wr_top       overwrite the top word with wr_data; combined with pop the
//                write lands on the entry that becomes the new top
//   wr_data      data for push / wr_top
//   clr          depth <= 0
//   top, next    s0 and s1 (top reads 0 when empty; next is meaningless below depth 2)
//   depth        current fill level
//   full, empty  depth == DEPTH / depth == 0
// The caller guarantees push/pop are never issued on full/empty.
module calc_ctx_stack
  import calc_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 6,
  localparam int unsigned DEP_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             wr_top,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [DEP_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEP_W-1:0] wr_idx;

  assign wr_idx = pop ? depth - DEP_W'(2) : depth - DEP_W'(1);
  assign full   = (depth == DEP_W'(DEPTH));
  assign empty  = (depth == '0);

  // Popped entries are left in place; only the depth counter moves.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && DEP_W'(i) == depth) begin
        mem[i] <= wr_data;
      end else if (wr_top && DEP_W'(i) == wr_idx) begin
        mem[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      depth <= '0;
    end else if (clr) begin
      depth <= '0;
    end else if (push) begin
      depth <= depth + DEP_W'(1);
    end else if (pop) begin
      depth <= depth - DEP_W'(1);
    end
  end

  // depth-1 wraps past every valid index when empty, so top stays 0 there
  always_comb begin
    top  = '0;
    next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DEP_W'(i) == depth - DEP_W'(1)) top  = mem[i];
      if (DEP_W'(i) == depth - DEP_W'(2)) next = mem[i];
    end
  end

endmodule

// File: rtl/calc_stack_engine.sv
// Multi-context WIDTH-lane boolean stack evaluator.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_ready = reset & (~res_valid | res_ready)
//   cmd_ctx             target context (out-of-range ids act as NOP on context 0)
//   cmd_op              opcode (calc_pkg OP_*)
//   cmd_lut             per-lane LUT indexed {s1,s0}; [1:0] is acc_op for ACC
//   cmd_val             operand for PUSH / ACC
//   err_clr             clear all sticky error flags
//   res_valid/ready     one-entry result buffer handshake
//   res_ctx/top/depth   context, top word and depth after the command
//   err_ovf, err_unf    sticky per-context overflow / underflow flags
module calc_stack_engine
  import calc_pkg::*;
#(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned DEPTH   = 6,
  parameter  int unsigned NUM_CTX = 2,
  localparam int unsigned CTX_W   = idx_w(NUM_CTX),
  localparam int unsigned DEP_W   = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CTX_W-1:0]   cmd_ctx,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_lut,
  input  logic [WIDTH-1:0]   cmd_val,
  input  logic               err_clr,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CTX_W-1:0]   res_ctx,
  output logic [WIDTH-1:0]   res_top,
  output logic [DEP_W-1:0]   res_depth,
  output logic [NUM_CTX-1:0] err_ovf,
  output logic [NUM_CTX-1:0] err_unf
);

  logic [WIDTH-1:0]   s_top   [NUM_CTX];
  logic [WIDTH-1:0]   s_next  [NUM_CTX];
  logic [DEP_W-1:0]   s_depth [NUM_CTX];
  logic [NUM_CTX-1:0] s_full, s_empty;
  logic [NUM_CTX-1:0] c_push, c_pop, c_wr, c_clr, c_set_ovf, c_set_unf;

  logic               accept;
  logic [CTX_W-1:0]   sel;
  logic [2:0]         op;
  logic [WIDTH-1:0]   cur_top, cur_next, lut_r, acc_r, wdata, nxt_top;
  logic [DEP_W-1:0]   cur_depth, nxt_depth;
  logic               cur_full, cur_empty;
  logic               push_c, pop_c, wr_c, clr_c, set_ovf_c, set_unf_c;

  assign cmd_ready = reset & (~res_valid | res_ready);
  assign accept    = cmd_valid & cmd_ready;

  for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
    calc_ctx_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push    (c_push[g]),
      .pop     (c_pop[g]),
      .wr_top  (c_wr[g]),
      .wr_data (wdata),
      .clr     (c_clr[g]),
      .top     (s_top[g]),
      .next    (s_next[g]),
      .depth   (s_depth[g]),
      .full    (s_full[g]),
      .empty   (s_empty[g])
    );
  end

  always_comb begin
    sel = '0;
    op  = OP_NOP;
    if (32'(cmd_ctx) < NUM_CTX) begin
      sel = cmd_ctx;
      op  = cmd_op;
    end

    cur_top   = '0;
    cur_next  = '0;
    cur_depth = '0;
    cur_full  = 1'b0;
    cur_empty = 1'b1;
    for (int unsigned i = 0; i < NUM_CTX; i++) begin
      if (CTX_W'(i) == sel) begin
        cur_top   = s_top[i];
        cur_next  = s_next[i];
        cur_depth = s_depth[i];
        cur_full  = s_full[i];
        cur_empty = s_empty[i];
      end
    end

    for (int unsigned i = 0; i < WIDTH; i++) begin
      lut_r[i] = cmd_lut[{cur_next[i], cur_top[i]}];
    end
    acc_r = (cmd_lut[ACC_INV_VAL] ? ~cmd_val : cmd_val) |
            (cmd_lut[ACC_INV_TOP] ? ~cur_top : cur_top);

    push_c    = 1'b0;
    pop_c     = 1'b0;
    wr_c      = 1'b0;
    clr_c     = 1'b0;
    set_ovf_c = 1'b0;
    set_unf_c = 1'b0;
    wdata     = cmd_val;
    nxt_top   = cur_top;
    nxt_depth = cur_depth;

    // nxt_* mirror what the stack will hold after the edge so the result
    // register can capture it in the same cycle the stack is updated.
    case (op)
      OP_PUSH: begin
        if (cur_full) begin
          set_ovf_c = 1'b1;
        end else begin
          push_c    = 1'b1;
          nxt_top   = cmd_val;
          nxt_depth = cur_depth + DEP_W'(1);
        end
      end
      OP_POP: begin
        if (cur_empty) begin
          set_unf_c = 1'b1;
        end else begin
          pop_c     = 1'b1;
          nxt_depth = cur_depth - DEP_W'(1);
          nxt_top   = (cur_depth > DEP_W'(1)) ? cur_next : '0;
        end
      end
      OP_LUT: begin
        if (cur_depth < DEP_W'(2)) begin
          set_unf_c = 1'b1;
        end else begin
          pop_c     = 1'b1;
          wr_c      = 1'b1;
          wdata     = lut_r;
          nxt_top   = lut_r;
          nxt_depth = cur_depth - DEP_W'(1);
        end
      end
      OP_ACC: begin
        if (cur_empty) begin
          set_unf_c = 1'b1;
        end else begin
          wr_c    = 1'b1;
          wdata   = acc_r;
          nxt_top = acc_r;
        end
      end
      OP_CLR: begin
        clr_c     = 1'b1;
        nxt_top   = '0;
        nxt_depth = '0;
      end
      default: ;
    endcase

    for (int unsigned i = 0; i < NUM_CTX; i++) begin
      c_push[i]    = accept && (CTX_W'(i) == sel) && push_c;
      c_pop[i]     = accept && (CTX_W'(i) == sel) && pop_c;
      c_wr[i]      = accept && (CTX_W'(i) == sel) && wr_c;
      c_clr[i]     = accept && (CTX_W'(i) == sel) && clr_c;
      c_set_ovf[i] = accept && (CTX_W'(i) == sel) && set_ovf_c;
      c_set_unf[i] = accept && (CTX_W'(i) == sel) && set_unf_c;
    end
  end

  // A flag raised this cycle beats any clear arriving with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_ovf <= '0;
      err_unf <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        if (c_set_ovf[i])             err_ovf[i] <= 1'b1;
        else if (err_clr || c_clr[i]) err_ovf[i] <= 1'b0;
        if (c_set_unf[i])             err_unf[i] <= 1'b1;
        else if (err_clr || c_clr[i]) err_unf[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_ctx   <= '0;
      res_top   <= '0;
      res_depth <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_ctx   <= sel;
      res_top   <= nxt_top;
      res_depth <= nxt_depth;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_stack_engine.sv
// Bench for calc_stack_engine (WIDTH=4, DEPTH=4, NUM_CTX=2): directed
// scenarios followed by randomized traffic against a queue-based model.
module tb_calc_stack_engine;

  localparam int W = 4;
  localparam int D = 4;
  localparam int N = 2;

  localparam int NOP = 0, PUSH = 1, POP = 2, LUT = 3, ACC = 4, CLR = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [0:0]   cmd_ctx = '0;
  logic [2:0]   cmd_op = '0;
  logic [3:0]   cmd_lut = '0;
  logic [W-1:0] cmd_val = '0;
  logic         err_clr = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [0:0]   res_ctx;
  logic [W-1:0] res_top;
  logic [2:0]   res_depth;
  logic [N-1:0] err_ovf, err_unf;

  calc_stack_engine #(.WIDTH(W), .DEPTH(D), .NUM_CTX(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ctx   (cmd_ctx),
    .cmd_op    (cmd_op),
    .cmd_lut   (cmd_lut),
    .cmd_val   (cmd_val),
    .err_clr   (err_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ctx   (res_ctx),
    .res_top   (res_top),
    .res_depth (res_depth),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [W-1:0] stk [N][$];
  bit           m_rv;
  int           m_rctx, m_rdepth;
  logic [W-1:0] m_rtop;
  logic [N-1:0] m_ovf, m_unf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cmd(input int c, input int op, input int lut, input int val, input bit ec);
    logic [N-1:0] set_o, set_u, clr_m;
    logic [W-1:0] s0, s1, r;
    logic [3:0]   lv;
    set_o = '0; set_u = '0; clr_m = '0;
    lv = 4'(lut);
    case (op)
      PUSH: if (stk[c].size() == D) set_o[c] = 1'b1; else stk[c].push_back(W'(val));
      POP:  if (stk[c].size() == 0) set_u[c] = 1'b1; else void'(stk[c].pop_back());
      LUT: begin
        if (stk[c].size() < 2) set_u[c] = 1'b1;
        else begin
          s0 = stk[c].pop_back();
          s1 = stk[c].pop_back();
          for (int i = 0; i < W; i++) r[i] = lv[{s1[i], s0[i]}];
          stk[c].push_back(r);
        end
      end
      ACC: begin
        if (stk[c].size() == 0) set_u[c] = 1'b1;
        else begin
          s0 = stk[c].pop_back();
          r  = (lv[1] ? ~W'(val) : W'(val)) | (lv[0] ? ~s0 : s0);
          stk[c].push_back(r);
        end
      end
      CLR: begin
        stk[c].delete();
        clr_m[c] = 1'b1;
      end
      default: ;
    endcase
    if (ec) clr_m = '1;
    m_ovf = (m_ovf & ~clr_m) | set_o;
    m_unf = (m_unf & ~clr_m) | set_u;
    m_rv     = 1'b1;
    m_rctx   = c;
    m_rdepth = stk[c].size();
    m_rtop   = (stk[c].size() > 0) ? stk[c][$] : '0;
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check #1 later.
  task automatic cyc(input bit v, input int c, input int op, input int lut, input int val,
                     input bit ec, input bit rr, input bit rn);
    bit exp_rdy;
    @(negedge clk);
    reset = rn; cmd_valid = v; cmd_ctx = 1'(c); cmd_op = 3'(op);
    cmd_lut = 4'(lut); cmd_val = W'(val); err_clr = ec; res_ready = rr;
    #1;
    exp_rdy = rn & (~m_rv | rr);
    check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < N; i++) stk[i].delete();
      m_rv = 1'b0; m_rctx = 0; m_rdepth = 0; m_rtop = '0; m_ovf = '0; m_unf = '0;
    end else if (v && exp_rdy) begin
      model_cmd(c < N ? c : 0, c < N ? op : NOP, lut, val, ec);
    end else begin
      if (ec) begin m_ovf = '0; m_unf = '0; end
      if (rr) m_rv = 1'b0;
    end
    #1;
    check_eq("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
    check_eq("res_ctx",   {31'd0, res_ctx}, m_rctx);
    check_eq("res_top",   {28'd0, res_top}, {28'd0, m_rtop});
    check_eq("res_depth", {29'd0, res_depth}, m_rdepth);
    check_eq("err_ovf",   {30'd0, err_ovf}, {30'd0, m_ovf});
    check_eq("err_unf",   {30'd0, err_unf}, {30'd0, m_unf});
  endtask

  initial begin
    m_rv = 1'b0; m_rctx = 0; m_rdepth = 0; m_rtop = '0; m_ovf = '0; m_unf = '0;

    // reset state
    cyc(1, 0, PUSH, 0, 5, 0, 1, 0);
    cyc(1, 0, PUSH, 0, 5, 0, 1, 0);
    check_eq("rst_valid", {31'd0, res_valid}, 32'd0);

    // 1. LUT as AND
    cyc(1, 0, PUSH, 0, 4'b1010, 0, 1, 1);
    cyc(1, 0, PUSH, 0, 4'b0110, 0, 1, 1);
    cyc(1, 0, LUT, 4'b1000, 0, 0, 1, 1);
    check_eq("t1_top", {28'd0, res_top}, 32'b0010);
    check_eq("t1_depth", {29'd0, res_depth}, 32'd1);
    check_eq("t1_err", {28'd0, err_ovf, err_unf}, 32'd0);

    // 2. ACC with acc_op=01
    cyc(1, 0, PUSH, 0, 4'b0011, 0, 1, 1);
    cyc(1, 0, ACC, 4'b0001, 4'b0101, 0, 1, 1);
    check_eq("t2_top", {28'd0, res_top}, 32'b1101);
    check_eq("t2_depth", {29'd0, res_depth}, 32'd2);

    // 3. overflow
    cyc(1, 0, CLR, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, PUSH, 0, i + 1, 0, 1, 1);
    check_eq("t3_depth", {29'd0, res_depth}, 32'd4);
    check_eq("t3_top", {28'd0, res_top}, 32'd4);
    check_eq("t3_ovf", {30'd0, err_ovf}, 32'b01);
    cyc(1, 1, NOP, 0, 0, 0, 1, 1);
    check_eq("t3_ctx1_depth", {29'd0, res_depth}, 32'd0);

    // 4. underflow, then set-wins-over-clear
    cyc(1, 0, CLR, 0, 0, 0, 1, 1);
    cyc(1, 0, PUSH, 0, 4'b1111, 0, 1, 1);
    cyc(1, 1, POP, 0, 0, 0, 1, 1);
    check_eq("t4_unf", {30'd0, err_unf}, 32'b10);
    check_eq("t4_top", {28'd0, res_top}, 32'd0);
    cyc(1, 0, LUT, 4'b1000, 0, 1, 1, 1);
    check_eq("t4_unf_set_wins", {30'd0, err_unf}, 32'b01);

    // 5. backpressure
    cyc(0, 0, NOP, 0, 0, 0, 1, 1);
    cyc(1, 1, PUSH, 0, 4'b1001, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, PUSH, 0, 4'b0111, 0, 0, 1);
      check_eq("t5_hold_top", {28'd0, res_top}, 32'b1001);
      check_eq("t5_hold_valid", {31'd0, res_valid}, 32'd1);
    end
    cyc(1, 1, PUSH, 0, 4'b0111, 0, 1, 1);
    check_eq("t5_taken_top", {28'd0, res_top}, 32'b0111);
    check_eq("t5_taken_depth", {29'd0, res_depth}, 32'd2);
    check_eq("t5_valid", {31'd0, res_valid}, 32'd1);

    // 6. reset mid-operation
    cyc(1, 0, CLR, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, PUSH, 0, i + 8, 0, 1, 1);
    cyc(1, 1, CLR, 0, 0, 0, 1, 1);
    cyc(1, 1, POP, 0, 0, 0, 1, 1);
    cyc(1, 0, PUSH, 0, 3, 0, 0, 0);
    check_eq("t6_valid", {31'd0, res_valid}, 32'd0);
    check_eq("t6_err", {28'd0, err_ovf, err_unf}, 32'd0);
    cyc(1, 0, NOP, 0, 0, 0, 1, 1);
    check_eq("t6_depth0", {29'd0, res_depth}, 32'd0);
    cyc(1, 1, NOP, 0, 0, 0, 1, 1);
    check_eq("t6_depth1", {29'd0, res_depth}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int op, r;
      r = $urandom_range(0, 15);
      op = (r < 5) ? PUSH : (r < 8) ? POP : (r < 11) ? LUT : (r < 13) ? ACC :
           (r == 13) ? CLR : $urandom_range(0, 7);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 1), op, $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
